// File: rtl/rib_pkg.sv
// Shared definitions for the rib_nxm N-master / M-slave request interconnect bus.
// Contents: the bus FSM state encoding, the slave-select field width, the width of the
// access timeout counter and the width of master index fields.
package rib_pkg;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StBusy = 1'b1
   } state_e;

   // Slave select is taken from the top SelW address bits.
   localparam int unsigned SelW    = 4;
   // Timeout counter width; TIMEOUT must be below 2**TmoCntW.
   localparam int unsigned TmoCntW = 16;
   // Master index width (up to 8 masters).
   localparam int unsigned IdxW    = 3;

endpackage

// File: rtl/rib_rr_arbiter.sv
// Combinational arbiter for the rib_nxm bus.
// Ports:
//   req_i     - request vector, one bit per master
//   rr_mode_i - 0: fixed priority (lowest index wins), 1: round-robin starting at ptr_i
//   ptr_i     - round-robin search start index
//   grant_o   - one-hot grant (all zero when nothing is requested)
module rib_rr_arbiter
   import rib_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 4
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic                   rr_mode_i,
   input  logic [IdxW-1:0]        ptr_i,
   output logic [NUM_MASTERS-1:0] grant_o
);

   always_comb begin
      int unsigned idx;
      logic        found;
      idx     = 0;
      found   = 1'b0;
      grant_o = '0;
      for (int unsigned off = 0; off < NUM_MASTERS; off++) begin
         // Fixed priority is a round-robin search that always starts at 0.
         idx = rr_mode_i ? (32'(ptr_i) + off) % NUM_MASTERS : off;
         for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (!found && (i == idx) && req_i[i]) begin
               grant_o[i] = 1'b1;
               found      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rib_nxm.sv
// rib_nxm: N-master to M-slave single-transaction bus with arbitration, address
// decode, decode-error and timeout handling, and a pipeline hold flag.
// Ports:
//   clk, rst             - clock, asynchronous active-low reset
//   m_addr_i, m_data_i   - flattened master address / write data
//   m_req_i, m_we_i      - per-master request and write enable
//   m_ready_o, m_data_o  - per-master completion pulse and read data
//   s_addr_o, s_data_o   - flattened slave address / write data
//   s_we_o, s_req_o      - per-slave write enable and request
//   s_data_i, s_ready_i  - per-slave read data and ready
//   hold_flag_o          - stall request to the core pipeline
//   err_o, err_id_o      - error pulse and index of the errored master
module rib_nxm
   import rib_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned NUM_SLAVES  = 8,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ARB_MODE    = 0,
   parameter int unsigned TIMEOUT     = 255,
   parameter logic [7:0]  HOLD_MASK   = 8'b0000_1101
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_data_i,
   output logic [NUM_MASTERS*DATA_W-1:0] m_data_o,
   input  logic [NUM_MASTERS-1:0]        m_req_i,
   input  logic [NUM_MASTERS-1:0]        m_we_i,
   output logic [NUM_MASTERS-1:0]        m_ready_o,
   output logic [NUM_SLAVES*ADDR_W-1:0]  s_addr_o,
   output logic [NUM_SLAVES*DATA_W-1:0]  s_data_o,
   input  logic [NUM_SLAVES*DATA_W-1:0]  s_data_i,
   output logic [NUM_SLAVES-1:0]         s_we_o,
   output logic [NUM_SLAVES-1:0]         s_req_o,
   input  logic [NUM_SLAVES-1:0]         s_ready_i,
   output logic                          hold_flag_o,
   output logic                          err_o,
   output logic [2:0]                    err_id_o
);

   state_e               state_q, state_d;
   logic [IdxW-1:0]      gnt_idx_q, gnt_idx_d;
   logic [IdxW-1:0]      ptr_q, ptr_d;
   logic [ADDR_W-1:0]    gnt_addr_q, gnt_addr_d;
   logic [DATA_W-1:0]    gnt_data_q, gnt_data_d;
   logic                 gnt_we_q, gnt_we_d;
   logic [TmoCntW-1:0]   cnt_q, cnt_d;

   logic [NUM_MASTERS-1:0] arb_grant;
   logic [IdxW-1:0]        win_idx;
   logic [ADDR_W-1:0]      win_addr;
   logic [DATA_W-1:0]      win_data;
   logic                   win_we;

   logic [SelW-1:0]   sel;
   logic [ADDR_W-1:0] slave_addr;
   logic              busy, dec_err, sel_ready, done, err, hold_gnt;
   logic [DATA_W-1:0] sel_rdata, rdata;

   rib_rr_arbiter #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_arb (
      .req_i     (m_req_i),
      .rr_mode_i (ARB_MODE == 1),
      .ptr_i     (ptr_q),
      .grant_o   (arb_grant)
   );

   // Mux the winning master's request fields.
   always_comb begin
      win_idx  = '0;
      win_addr = '0;
      win_data = '0;
      win_we   = 1'b0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (arb_grant[i]) begin
            win_idx  = IdxW'(i);
            win_addr = m_addr_i[i*ADDR_W +: ADDR_W];
            win_data = m_data_i[i*DATA_W +: DATA_W];
            win_we   = m_we_i[i];
         end
      end
   end

   assign busy       = (state_q == StBusy);
   assign sel        = gnt_addr_q[ADDR_W-1 -: SelW];
   assign slave_addr = {{SelW{1'b0}}, gnt_addr_q[ADDR_W-SelW-1:0]};
   assign dec_err    = (32'(sel) >= NUM_SLAVES);

   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
         if (32'(sel) == s) begin
            sel_ready = s_ready_i[s];
            sel_rdata = s_data_i[s*DATA_W +: DATA_W];
         end
      end
   end

   // Slave/master outputs and completion; everything is quiet outside BUSY.
   always_comb begin
      s_req_o   = '0;
      s_we_o    = '0;
      s_addr_o  = '0;
      s_data_o  = '0;
      m_ready_o = '0;
      m_data_o  = '0;
      err_o     = 1'b0;
      err_id_o  = '0;
      done      = 1'b0;
      err       = 1'b0;
      rdata     = '0;
      if (busy) begin
         for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
            if (!dec_err && (32'(sel) == s)) begin
               s_req_o[s]                    = 1'b1;
               s_we_o[s]                     = gnt_we_q;
               s_addr_o[s*ADDR_W +: ADDR_W]  = slave_addr;
               s_data_o[s*DATA_W +: DATA_W]  = gnt_data_q;
            end
         end
         if (dec_err) begin
            done = 1'b1;
            err  = 1'b1;
         end else if (sel_ready) begin
            done  = 1'b1;
            rdata = gnt_we_q ? '0 : sel_rdata;
         end else if (cnt_q == TmoCntW'(TIMEOUT)) begin
            done = 1'b1;
            err  = 1'b1;
         end
         for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (32'(gnt_idx_q) == i) begin
               m_ready_o[i]                 = done;
               m_data_o[i*DATA_W +: DATA_W] = rdata;
            end
         end
         err_o    = err;
         err_id_o = err ? 3'(gnt_idx_q) : 3'b0;
      end
   end

   always_comb begin
      hold_gnt = 1'b0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (32'(gnt_idx_q) == i) hold_gnt = HOLD_MASK[i];
      end
   end

   // Gated by rst so the flag drops immediately while reset is held.
   assign hold_flag_o = rst & ((|(m_req_i & HOLD_MASK[NUM_MASTERS-1:0])) | (busy & hold_gnt));

   always_comb begin
      state_d    = state_q;
      gnt_idx_d  = gnt_idx_q;
      gnt_addr_d = gnt_addr_q;
      gnt_data_d = gnt_data_q;
      gnt_we_d   = gnt_we_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (|m_req_i) begin
               state_d    = StBusy;
               gnt_idx_d  = win_idx;
               gnt_addr_d = win_addr;
               gnt_data_d = win_data;
               gnt_we_d   = win_we;
               cnt_d      = '0;
               if (ARB_MODE == 1) begin
                  ptr_d = (32'(win_idx) + 1 == NUM_MASTERS) ? '0 : win_idx + IdxW'(1);
               end
            end
         end
         StBusy: begin
            // Grant stays locked until completion; new requests wait for IDLE.
            if (done) state_d = StIdle;
            else      cnt_d   = cnt_q + TmoCntW'(1);
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         gnt_idx_q  <= '0;
         gnt_addr_q <= '0;
         gnt_data_q <= '0;
         gnt_we_q   <= 1'b0;
         ptr_q      <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         gnt_idx_q  <= gnt_idx_d;
         gnt_addr_q <= gnt_addr_d;
         gnt_data_q <= gnt_data_d;
         gnt_we_q   <= gnt_we_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_rib_nxm.sv
// Bench for rib_nxm: a round-robin instance (main DUT) and a fixed-priority instance
// share the master-side stimulus; each has its own behavioural slave model.
module tb_rib_nxm;

   localparam int NM = 4;
   localparam int NS = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [NM*32-1:0] m_addr, m_wdata;
   logic [NM-1:0]  m_req, m_we;
   logic [7:0]     rdy_en;

   logic [NM*32-1:0] rr_m_rdata, fp_m_rdata;
   logic [NM-1:0]    rr_m_ready, fp_m_ready;
   logic [NS*32-1:0] rr_s_addr, rr_s_wdata, rr_s_rdata, fp_s_addr, fp_s_wdata, fp_s_rdata;
   logic [NS-1:0]    rr_s_we, rr_s_req, rr_s_ready, fp_s_we, fp_s_req, fp_s_ready;
   logic             rr_hold, rr_err, fp_hold, fp_err;
   logic [2:0]       rr_err_id, fp_err_id;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rib_nxm #(
      .NUM_MASTERS (NM), .NUM_SLAVES (NS), .ADDR_W (32), .DATA_W (32),
      .ARB_MODE (1), .TIMEOUT (10), .HOLD_MASK (8'b0000_1101)
   ) dut (
      .clk (clk), .rst (rst), .m_addr_i (m_addr), .m_data_i (m_wdata),
      .m_data_o (rr_m_rdata), .m_req_i (m_req), .m_we_i (m_we), .m_ready_o (rr_m_ready),
      .s_addr_o (rr_s_addr), .s_data_o (rr_s_wdata), .s_data_i (rr_s_rdata),
      .s_we_o (rr_s_we), .s_req_o (rr_s_req), .s_ready_i (rr_s_ready),
      .hold_flag_o (rr_hold), .err_o (rr_err), .err_id_o (rr_err_id)
   );

   rib_nxm #(
      .NUM_MASTERS (NM), .NUM_SLAVES (NS), .ADDR_W (32), .DATA_W (32),
      .ARB_MODE (0), .TIMEOUT (10), .HOLD_MASK (8'b0000_1101)
   ) dut_fp (
      .clk (clk), .rst (rst), .m_addr_i (m_addr), .m_data_i (m_wdata),
      .m_data_o (fp_m_rdata), .m_req_i (m_req), .m_we_i (m_we), .m_ready_o (fp_m_ready),
      .s_addr_o (fp_s_addr), .s_data_o (fp_s_wdata), .s_data_i (fp_s_rdata),
      .s_we_o (fp_s_we), .s_req_o (fp_s_req), .s_ready_i (fp_s_ready),
      .hold_flag_o (fp_hold), .err_o (fp_err), .err_id_o (fp_err_id)
   );

   // Slave 1 always returns 0xDEADBEEF; others return {index, 0x5A5, addr[15:0]}.
   function automatic logic [31:0] slave_rdata(input int s, input logic [31:0] a);
      if (s == 1) return 32'hDEAD_BEEF;
      return {4'(s), 12'h5A5, a[15:0]};
   endfunction

   always_comb begin
      rr_s_rdata = '0;
      rr_s_ready = '0;
      fp_s_rdata = '0;
      fp_s_ready = '0;
      for (int s = 0; s < NS; s++) begin
         rr_s_rdata[s*32 +: 32] = slave_rdata(s, rr_s_addr[s*32 +: 32]);
         rr_s_ready[s]          = rr_s_req[s] & rdy_en[s];
         fp_s_rdata[s*32 +: 32] = slave_rdata(s, fp_s_addr[s*32 +: 32]);
         fp_s_ready[s]          = fp_s_req[s] & rdy_en[s];
      end
   end

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   typedef struct {
      int          m;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } vec_t;

   typedef struct {
      int          master;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   arb_q[$];

   task automatic run_vec(input vec_t v);
      int           lat;
      int           sel;
      logic         seen_req;
      logic         timed_out;
      exp_t         e;
      logic [3:0]   er;
      logic [127:0] ed;
      sel = int'(v.addr[31:28]);
      @(negedge clk);
      m_req                    = '0;
      m_req[v.m]               = 1'b1;
      m_we[v.m]                = v.we;
      m_addr[v.m*32 +: 32]     = v.addr;
      m_wdata[v.m*32 +: 32]    = v.wdata;
      sb.push_back('{master: v.m, data: v.rdata, err: v.err});
      lat       = 0;
      seen_req  = 1'b0;
      timed_out = 1'b0;
      while (!timed_out) begin
         @(negedge clk);
         lat++;
         if ((|rr_s_req) && !seen_req) begin
            seen_req = 1'b1;
            check("s_req onehot", rr_s_req, 256'(1) << sel);
            check("s_addr", rr_s_addr[sel*32 +: 32], {4'h0, v.addr[27:0]});
            check("s_we", rr_s_we[sel], v.we);
            if (v.we) check("s_wdata", rr_s_wdata[sel*32 +: 32], v.wdata);
         end
         if (|rr_m_ready) break;
         if (lat >= 50) begin
            timed_out = 1'b1;
            check("ready wait expired", 1'b0, 1'b1);
         end
      end
      m_req = '0;
      e  = sb.pop_front();
      er = '0;
      er[e.master] = 1'b1;
      ed = '0;
      ed[e.master*32 +: 32] = e.data;
      check("m_ready", rr_m_ready, er);
      check("m_data", rr_m_rdata, ed);
      check("err", rr_err, e.err);
      check("err_id", rr_err_id, e.err ? 3'(e.master) : 3'd0);
      check("latency", lat, v.lat);
      check("slave req issued", seen_req, (sel < NS) ? 1'b1 : 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vt[9];
      int   lat;
      logic hold_low, stale, bad_grant;
      logic [127:0] ed;

      vt[0] = '{0, 1'b0, 32'h1000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, 1};
      vt[1] = '{1, 1'b1, 32'h2000_0010, 32'h1234_5678, 32'h0,         1'b0, 1};
      vt[2] = '{3, 1'b0, 32'h7ABC_0020, 32'h0,         32'h75A5_0020, 1'b0, 1};
      vt[3] = '{2, 1'b0, 32'h9000_0000, 32'h0,         32'h0,         1'b1, 1};
      vt[4] = '{1, 1'b0, 32'hF000_0000, 32'h0,         32'h0,         1'b1, 1};
      vt[5] = '{3, 1'b1, 32'h3000_0000, 32'hCAFE_F00D, 32'h0,         1'b1, 11};
      vt[6] = '{0, 1'b0, 32'h0000_0100, 32'h0,         32'h05A5_0100, 1'b0, 1};
      vt[7] = '{2, 1'b0, 32'h2FFF_FFFC, 32'h0,         32'h25A5_FFFC, 1'b0, 1};
      vt[8] = '{3, 1'b0, 32'h3000_0040, 32'h0,         32'h0,         1'b1, 11};

      rst     = 1'b0;
      m_req   = '0;
      m_we    = '0;
      m_addr  = '0;
      m_wdata = '0;
      rdy_en  = 8'hF7;   // slave 3 never answers
      #2;
      check("reset m_ready", rr_m_ready, 4'h0);
      check("reset m_data", rr_m_rdata, 128'h0);
      check("reset s_req", rr_s_req, 8'h0);
      check("reset s_addr", rr_s_addr, 256'h0);
      check("reset err", rr_err, 1'b0);
      check("reset hold", rr_hold, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      foreach (vt[i]) run_vec(vt[i]);

      // Hold flag: m1 is outside the hold mask.
      @(negedge clk);
      m_req = 4'b0010;
      m_we  = '0;
      m_addr[1*32 +: 32] = 32'h2000_0000;
      #1 check("hold m1 request", rr_hold, 1'b0);
      @(negedge clk);
      check("hold m1 busy", rr_hold, 1'b0);
      check("m1 ready", rr_m_ready, 4'b0010);
      m_req = '0;

      // m0 to a silent slave: hold until its forced completion; m0 drops its request
      // mid-access and m1 requests while busy.
      @(negedge clk);
      m_req = 4'b0001;
      m_addr[0*32 +: 32] = 32'h3000_0008;
      #1 check("hold m0 request", rr_hold, 1'b1);
      lat       = 0;
      hold_low  = 1'b0;
      bad_grant = 1'b0;
      while (lat < 50) begin
         @(negedge clk);
         lat++;
         m_req = 4'b0010;
         if (!rr_hold) hold_low = 1'b1;
         if (rr_m_ready[1] || (rr_s_req != 8'b0000_1000)) bad_grant = 1'b1;
         if (|rr_m_ready) break;
      end
      check("hold kept while m0 busy", hold_low, 1'b0);
      check("m1 ignored while busy", bad_grant, 1'b0);
      check("m0 ready after drop", rr_m_ready, 4'b0001);
      check("m0 timeout latency", lat, 11);
      check("m0 timeout err", rr_err, 1'b1);
      m_req = '0;
      @(negedge clk);
      check("hold released", rr_hold, 1'b0);

      // Reset during a stalled access.
      @(negedge clk);
      m_req = 4'b1000;
      m_we  = 4'b0000;
      m_addr[3*32 +: 32] = 32'h3000_0004;
      repeat (3) @(negedge clk);
      check("busy before reset", rr_s_req, 8'b0000_1000);
      rst = 1'b0;
      #1;
      check("rst m_ready", rr_m_ready, 4'h0);
      check("rst s_req", rr_s_req, 8'h0);
      check("rst s_addr", rr_s_addr, 256'h0);
      check("rst hold", rr_hold, 1'b0);
      check("rst err", rr_err, 1'b0);
      m_req = '0;
      @(negedge clk);
      rst   = 1'b1;
      stale = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (|rr_m_ready) stale = 1'b1;
      end
      check("no stale ready", stale, 1'b0);

      // Arbitration: all masters held high, starting from the reset pointer.
      arb_q = '{0, 1, 2, 3, 0};
      @(negedge clk);
      for (int i = 0; i < NM; i++) m_addr[i*32 +: 32] = 32'h2000_0000 | 32'(i << 4);
      m_we  = '0;
      m_req = 4'hF;
      for (int k = 0; k < 5; k++) begin
         int exp_m;
         logic [3:0] er;
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
         end while (!(|rr_m_ready) && lat < 20);
         exp_m = arb_q.pop_front();
         er = '0;
         er[exp_m] = 1'b1;
         ed = '0;
         ed[exp_m*32 +: 32] = {16'h25A5, 16'(exp_m << 4)};
         check("rr grant", rr_m_ready, er);
         check("rr data", rr_m_rdata, ed);
         check("fp grant", fp_m_ready, 4'b0001);
      end
      m_req = '0;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rib_nxm.md
RIB_NXM -- requirements
Module: rib_nxm

Interface
REQ-001 Parameter NUM_MASTERS, default 4, number of bus masters (1..8).
REQ-002 Parameter NUM_SLAVES, default 8, number of slaves (1..16).
REQ-003 Parameter ADDR_W, default 32, address width; DATA_W, default 32, data width.
REQ-004 Parameter ARB_MODE, default 0; 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-005 Parameter TIMEOUT, default 255, cycles a slave may take before forced completion.
REQ-006 Parameter HOLD_MASK, default 4'b1101, masters whose pending requests raise hold_flag_o.
REQ-007 clk  in  1  single clock, all state on rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 m_addr_i  in  NUM_MASTERS*ADDR_W  flattened master addresses.
REQ-010 m_data_i  in  NUM_MASTERS*DATA_W  master write data; m_data_o  out  same width  read data.
REQ-011 m_req_i, m_we_i  in  NUM_MASTERS  request and write enable per master.
REQ-012 m_ready_o  out  NUM_MASTERS  one-cycle completion pulse per master.
REQ-013 s_addr_o  out  NUM_SLAVES*ADDR_W; s_data_o  out  NUM_SLAVES*DATA_W; s_data_i  in  NUM_SLAVES*DATA_W.
REQ-014 s_we_o, s_req_o  out  NUM_SLAVES; s_ready_i  in  NUM_SLAVES.
REQ-015 hold_flag_o  out  1  stall request to core pipeline.
REQ-016 err_o  out  1  one-cycle pulse on decode error or timeout; err_id_o  out  3  master index of errored access.

Function
REQ-017 Slave select = addr[ADDR_W-1:ADDR_W-4]; slave address = addr with top 4 bits zeroed.
REQ-018 FSM states IDLE, BUSY; IDLE -> BUSY when any m_req_i high; BUSY -> IDLE on completion.
REQ-019 In IDLE, winner chosen per ARB_MODE, latched with its addr/data/we into grant registers.
REQ-020 Round-robin: pointer resets to 0; search starts at pointer; after grant to i, pointer = (i+1) mod NUM_MASTERS.
REQ-021 In BUSY, s_req_o/s_we_o/s_addr_o/s_data_o of selected slave driven from grant registers; all other slave outputs 0.
REQ-022 Completion: selected s_ready_i high in BUSY -> m_ready_o[granted] high same cycle, m_data_o slice = s_data_i of slave; next state IDLE.
REQ-023 Minimum latency, always-ready slave: req at cycle 0 -> m_ready_o at cycle 1; one access per 2 cycles per master.
REQ-024 Grant locked in BUSY; deasserting m_req_i mid-access does not abort; ready still pulsed.
REQ-025 Decode error (select >= NUM_SLAVES): no s_req_o; first BUSY cycle pulses m_ready_o, data 0, err_o=1, err_id_o=index.
REQ-026 Timeout: counter clears on IDLE->BUSY; at TIMEOUT cycles in BUSY without ready -> forced completion, data 0, err_o=1.
REQ-027 Non-granted m_data_o slices and m_ready_o bits are 0.
REQ-028 hold_flag_o = OR of m_req_i[i] & HOLD_MASK[i], OR (BUSY and HOLD_MASK[granted]).
REQ-029 Simultaneous new requests while BUSY are ignored until IDLE; write ready pulses carry data 0.

Reset
REQ-030 Reset low: state IDLE, grant/pointer/counter 0, all outputs 0, immediately and independent of clk.
REQ-031 Reset mid-access aborts it; no m_ready_o pulse issued for that access.

Structure
REQ-032 Package rib_pkg holds state encoding, slave-select width (4), and TIMEOUT counter width.
REQ-033 One sub-module rib_rr_arbiter (request vector, mode, pointer -> one-hot grant), combinational.

Verification
REQ-034 m0 reads 0x1000_0004, slave1 returns 0xDEADBEEF ready at once -> s_addr_o[1]=0x0000_0004, m_ready_o[0] at cycle 1 with 0xDEADBEEF.
REQ-035 ARB_MODE=1, m0..m3 held high -> grants 0,1,2,3,0 in successive accesses; ARB_MODE=0 -> always 0.
REQ-036 NUM_SLAVES=8, m2 accesses 0x9000_0000 -> no s_req_o, err_o=1, err_id_o=2, m_ready_o[2]=1, data 0.
REQ-037 TIMEOUT=10, slave3 never ready -> m_ready_o pulse and err_o exactly 10 cycles after entering BUSY.
REQ-038 m1 (not in HOLD_MASK) alone requesting -> hold_flag_o=0; m0 requesting -> hold_flag_o=1 until its ready.
REQ-039 rst low during BUSY with slow slave -> outputs 0 same cycle; after release, no stale ready and pointer 0.
